// File: rtl/ahblite_interconnect.sv
// AHB-Lite single-master interconnect: address decode to four slaves plus an
// internal default slave, with a data-phase select register for response muxing.
module ahblite_interconnect #(
  parameter logic [7:0] S0_BASE = 8'h00,
  parameter logic [7:0] S1_BASE = 8'h20,
  parameter logic [7:0] S2_BASE = 8'h40,
  parameter logic [7:0] S3_BASE = 8'h50
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  output logic        HSEL_S0,
  output logic        HSEL_S1,
  output logic        HSEL_S2,
  output logic        HSEL_S3,
  input  logic        HREADYOUT_S0,
  input  logic        HREADYOUT_S1,
  input  logic        HREADYOUT_S2,
  input  logic        HREADYOUT_S3,
  input  logic [31:0] HRDATA_S0,
  input  logic [31:0] HRDATA_S1,
  input  logic [31:0] HRDATA_S2,
  input  logic [31:0] HRDATA_S3,
  input  logic        HRESP_S0,
  input  logic        HRESP_S1,
  input  logic        HRESP_S2,
  input  logic        HRESP_S3,
  output logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HRESP
);

  typedef enum logic [2:0] {
    SEL_S0 = 3'd0,
    SEL_S1 = 3'd1,
    SEL_S2 = 3'd2,
    SEL_S3 = 3'd3,
    SEL_DS = 3'd4
  } sel_e;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  sel_e      dec_s;
  sel_e      dpsel_r;
  ds_state_e ds_state_r;
  ds_state_e ds_next_s;
  logic      ds_req_s;
  logic      ds_ready_s;
  logic      ds_resp_s;
  logic      hready_s;
  logic      hresp_s;
  logic [31:0] hrdata_s;

  // Priority chain guarantees a single select even if two bases overlap
  always_comb begin
    dec_s = SEL_DS;
    if (HADDR[31:24] == S0_BASE) begin
      dec_s = SEL_S0;
    end else if (HADDR[31:24] == S1_BASE) begin
      dec_s = SEL_S1;
    end else if (HADDR[31:24] == S2_BASE) begin
      dec_s = SEL_S2;
    end else if (HADDR[31:24] == S3_BASE) begin
      dec_s = SEL_S3;
    end else begin
      dec_s = SEL_DS;
    end
  end

  assign HSEL_S0 = (dec_s == SEL_S0);
  assign HSEL_S1 = (dec_s == SEL_S1);
  assign HSEL_S2 = (dec_s == SEL_S2);
  assign HSEL_S3 = (dec_s == SEL_S3);

  // Only NONSEQ/SEQ to an unmapped address earns an ERROR; IDLE/BUSY stay OKAY
  assign ds_req_s = (dec_s == SEL_DS) && HTRANS[1];

  // Data-phase select follows the decode only when the current transfer completes
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dpsel_r <= SEL_DS;
    end else if (hready_s) begin
      dpsel_r <= dec_s;
    end else begin
      dpsel_r <= dpsel_r;
    end
  end

  // Default-slave state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ds_state_r <= DS_IDLE;
    end else begin
      ds_state_r <= ds_next_s;
    end
  end

  // Default-slave next state and its two-cycle ERROR response
  always_comb begin
    ds_next_s  = DS_IDLE;
    ds_ready_s = 1'b1;
    ds_resp_s  = 1'b0;
    case (ds_state_r)
      DS_IDLE: begin
        ds_ready_s = 1'b1;
        ds_resp_s  = 1'b0;
        if (hready_s && ds_req_s) begin
          ds_next_s = DS_ERR1;
        end else begin
          ds_next_s = DS_IDLE;
        end
      end
      DS_ERR1: begin
        ds_ready_s = 1'b0;
        ds_resp_s  = 1'b1;
        ds_next_s  = DS_ERR2;
      end
      DS_ERR2: begin
        ds_ready_s = 1'b1;
        ds_resp_s  = 1'b1;
        if (ds_req_s) begin
          ds_next_s = DS_ERR1;
        end else begin
          ds_next_s = DS_IDLE;
        end
      end
      default: begin
        ds_ready_s = 1'b1;
        ds_resp_s  = 1'b0;
        ds_next_s  = DS_IDLE;
      end
    endcase
  end

  // Response mux driven purely from the registered data-phase select
  always_comb begin
    hready_s = 1'b1;
    hresp_s  = 1'b0;
    hrdata_s = 32'h0000_0000;
    case (dpsel_r)
      SEL_S0: begin
        hready_s = HREADYOUT_S0;
        hresp_s  = HRESP_S0;
        hrdata_s = HRDATA_S0;
      end
      SEL_S1: begin
        hready_s = HREADYOUT_S1;
        hresp_s  = HRESP_S1;
        hrdata_s = HRDATA_S1;
      end
      SEL_S2: begin
        hready_s = HREADYOUT_S2;
        hresp_s  = HRESP_S2;
        hrdata_s = HRDATA_S2;
      end
      SEL_S3: begin
        hready_s = HREADYOUT_S3;
        hresp_s  = HRESP_S3;
        hrdata_s = HRDATA_S3;
      end
      SEL_DS: begin
        hready_s = ds_ready_s;
        hresp_s  = ds_resp_s;
        hrdata_s = 32'h0000_0000;
      end
      default: begin
        hready_s = 1'b1;
        hresp_s  = 1'b0;
        hrdata_s = 32'h0000_0000;
      end
    endcase
  end

  assign HREADY = hready_s;
  assign HRESP  = hresp_s;
  assign HRDATA = hrdata_s;

endmodule

// File: tb/tb_ahblite_interconnect.sv
// Directed self-checking bench for ahblite_interconnect: decode, wait states,
// default-slave ERROR, slave ERROR pass-through, pipelining and reset.
module tb_ahblite_interconnect;

  logic        HCLK;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HSEL_S0, HSEL_S1, HSEL_S2, HSEL_S3;
  logic        HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3;
  logic [31:0] HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3;
  logic        HRESP_S0, HRESP_S1, HRESP_S2, HRESP_S3;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [31:0] D_S0 = 32'hDEAD_BEEF;
  localparam logic [31:0] D_S1 = 32'h1111_2222;
  localparam logic [31:0] D_S2 = 32'h2222_3333;
  localparam logic [31:0] D_S3 = 32'h3333_4444;

  ahblite_interconnect dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSEL_S0(HSEL_S0), .HSEL_S1(HSEL_S1), .HSEL_S2(HSEL_S2), .HSEL_S3(HSEL_S3),
    .HREADYOUT_S0(HREADYOUT_S0), .HREADYOUT_S1(HREADYOUT_S1),
    .HREADYOUT_S2(HREADYOUT_S2), .HREADYOUT_S3(HREADYOUT_S3),
    .HRDATA_S0(HRDATA_S0), .HRDATA_S1(HRDATA_S1),
    .HRDATA_S2(HRDATA_S2), .HRDATA_S3(HRDATA_S3),
    .HRESP_S0(HRESP_S0), .HRESP_S1(HRESP_S1), .HRESP_S2(HRESP_S2), .HRESP_S3(HRESP_S3),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Advance one cycle: wait for the edge, then drive new address-phase inputs
  task automatic step(input logic [31:0] addr, input logic [1:0] trans);
    @(posedge HCLK);
    #1;
    HADDR  = addr;
    HTRANS = trans;
    #1;
  endtask

  task automatic chk_resp(input string name, input logic rdy, input logic rsp, input logic [31:0] dat);
    checks++; if (HREADY !== rdy) begin errors++; $display("FAIL %s HREADY got %b exp %b", name, HREADY, rdy); end
    checks++; if (HRESP !== rsp) begin errors++; $display("FAIL %s HRESP got %b exp %b", name, HRESP, rsp); end
    checks++; if (HRDATA !== dat) begin errors++; $display("FAIL %s HRDATA got %h exp %h", name, HRDATA, dat); end
  endtask

  task automatic chk_sel(input string name, input logic [3:0] exp_sel);
    checks++;
    if ({HSEL_S3, HSEL_S2, HSEL_S1, HSEL_S0} !== exp_sel) begin
      errors++;
      $display("FAIL %s HSEL[3:0] got %b exp %b", name, {HSEL_S3, HSEL_S2, HSEL_S1, HSEL_S0}, exp_sel);
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    HADDR = 32'h9000_0000; HTRANS = T_NONSEQ;
    HREADYOUT_S0 = 1'b1; HREADYOUT_S1 = 1'b1; HREADYOUT_S2 = 1'b1; HREADYOUT_S3 = 1'b1;
    HRDATA_S0 = D_S0; HRDATA_S1 = D_S1; HRDATA_S2 = D_S2; HRDATA_S3 = D_S3;
    HRESP_S0 = 1'b0; HRESP_S1 = 1'b0; HRESP_S2 = 1'b0; HRESP_S3 = 1'b0;
    repeat (2) @(posedge HCLK);
    #2;
    chk_resp("reset_out", 1'b1, 1'b0, 32'h0000_0000);
    chk_sel("reset_unmapped_sel", 4'b0000);
    HTRANS = T_IDLE;
    #1 HRESETn = 1'b1;
  endtask

  task automatic test_s0_read();
    step(32'h0000_0010, T_NONSEQ);
    chk_sel("s0_addr_sel", 4'b0001);
    chk_resp("s0_addr_phase", 1'b1, 1'b0, 32'h0000_0000);
    step(32'h9000_0000, T_IDLE);
    chk_resp("s0_data_phase", 1'b1, 1'b0, D_S0);
  endtask

  task automatic test_wait_states();
    int low_cnt;
    step(32'h4000_0004, T_NONSEQ);
    chk_sel("s2_addr_sel", 4'b0100);
    low_cnt = 0;
    step(32'h0000_0000, T_IDLE);
    HREADYOUT_S2 = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step(32'h0000_0000, T_IDLE);
      if (HREADY === 1'b0) low_cnt++;
      checks++; if (HRDATA !== D_S2) begin errors++; $display("FAIL s2_wait_hold cycle %0d HRDATA got %h exp %h", i, HRDATA, D_S2); end
    end
    checks++; if (low_cnt != 3) begin errors++; $display("FAIL s2_wait_count got %0d exp 3", low_cnt); end
    step(32'h0000_0000, T_IDLE);
    HREADYOUT_S2 = 1'b1;
    #1;
    chk_resp("s2_complete", 1'b1, 1'b0, D_S2);
    chk_sel("s2_next_decode", 4'b0001);
    step(32'h9000_0000, T_IDLE);
    chk_resp("s2_then_s0", 1'b1, 1'b0, D_S0);
  endtask

  task automatic test_unmapped_error();
    step(32'h9000_0000, T_NONSEQ);
    chk_sel("ds_addr_sel", 4'b0000);
    chk_resp("ds_addr_phase", 1'b1, 1'b0, 32'h0000_0000);
    step(32'h9000_0000, T_IDLE);
    chk_resp("ds_err1", 1'b0, 1'b1, 32'h0000_0000);
    step(32'h9000_0000, T_IDLE);
    chk_resp("ds_err2", 1'b1, 1'b1, 32'h0000_0000);
    step(32'h9000_0000, T_IDLE);
    chk_resp("ds_back_idle", 1'b1, 1'b0, 32'h0000_0000);
  endtask

  task automatic test_idle_unmapped();
    step(32'h9000_0000, T_IDLE);
    step(32'h9000_0000, T_BUSY);
    chk_resp("idle_unmapped", 1'b1, 1'b0, 32'h0000_0000);
    step(32'h9000_0000, T_IDLE);
    chk_resp("busy_unmapped", 1'b1, 1'b0, 32'h0000_0000);
  endtask

  task automatic test_back_to_back();
    step(32'h0000_0000, T_NONSEQ);
    chk_sel("b2b_s0_sel", 4'b0001);
    step(32'h2000_0000, T_NONSEQ);
    HREADYOUT_S0 = 1'b0;
    #1;
    chk_sel("b2b_s1_sel_stall", 4'b0010);
    chk_resp("b2b_s0_stall", 1'b0, 1'b0, D_S0);
    step(32'h2000_0000, T_NONSEQ);
    HREADYOUT_S0 = 1'b1;
    #1;
    chk_sel("b2b_s1_sel_held", 4'b0010);
    chk_resp("b2b_s0_done", 1'b1, 1'b0, D_S0);
    step(32'h9000_0000, T_IDLE);
    chk_resp("b2b_s1_data", 1'b1, 1'b0, D_S1);
  endtask

  task automatic test_slave_error();
    step(32'h5000_0000, T_NONSEQ);
    chk_sel("s3_addr_sel", 4'b1000);
    step(32'h2000_0000, T_NONSEQ);
    HREADYOUT_S3 = 1'b0; HRESP_S3 = 1'b1;
    #1;
    chk_resp("s3_err_first", 1'b0, 1'b1, D_S3);
    step(32'h2000_0000, T_NONSEQ);
    HREADYOUT_S3 = 1'b1;
    #1;
    chk_resp("s3_err_second", 1'b1, 1'b1, D_S3);
    step(32'h9000_0000, T_IDLE);
    HRESP_S3 = 1'b0;
    #1;
    chk_resp("s3_err_advance", 1'b1, 1'b0, D_S1);
  endtask

  task automatic test_reset_mid_error();
    step(32'h9000_0000, T_NONSEQ);
    step(32'h9000_0000, T_IDLE);
    chk_resp("rst_pre_err1", 1'b0, 1'b1, 32'h0000_0000);
    #1 HRESETn = 1'b0;
    #1;
    chk_resp("rst_async", 1'b1, 1'b0, 32'h0000_0000);
    @(posedge HCLK);
    #2;
    chk_resp("rst_held", 1'b1, 1'b0, 32'h0000_0000);
    HADDR = 32'h0000_0000; HTRANS = T_NONSEQ;
    #1 HRESETn = 1'b1;
    #1;
    chk_resp("rst_release", 1'b1, 1'b0, 32'h0000_0000);
    step(32'h9000_0000, T_IDLE);
    chk_resp("rst_first_phase", 1'b1, 1'b0, D_S0);
  endtask

  initial begin
    test_reset();
    test_s0_read();
    test_wait_states();
    test_unmapped_error();
    test_idle_unmapped();
    test_back_to_back();
    test_slave_error();
    test_reset_mid_error();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
